// File: rtl/nmea_pkg.sv
// Shared definitions for the NMEA sentence transmitter: ASCII framing characters,
// FSM state encoding and the nibble-to-hex helper used for the checksum digits.
package nmea_pkg;

    localparam logic [7:0] ASCII_DOLLAR = 8'h24;
    localparam logic [7:0] ASCII_STAR   = 8'h2A;
    localparam logic [7:0] ASCII_COMMA  = 8'h2C;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SOF,
        ST_BODY,
        ST_STAR,
        ST_HI,
        ST_LO,
        ST_CR,
        ST_LF,
        ST_DONE
    } nmea_state_e;

    // Uppercase hex digit for one checksum nibble.
    function automatic logic [7:0] nib2hex(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/nmea_uart_serializer.sv
// UART 8N1 character serializer: baud counter plus a 10-bit frame shift register.
// idle is also high in the final cycle of a stop bit so characters run back-to-back.
module nmea_uart_serializer #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       idle,
    output logic       bit_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);

    logic [BAUD_W-1:0] r_baud;
    logic [3:0]        r_bit;
    logic              r_busy;
    logic [9:0]        r_shift;
    logic              w_bit_end;
    logic              w_last;

    assign w_bit_end = r_busy && (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign w_last    = w_bit_end && (r_bit == 4'd9);
    assign idle      = !r_busy || w_last;
    assign bit_done  = w_bit_end;
    assign tx        = r_shift[0];

    // Shifting in ones behind the frame leaves the line high once the stop bit is out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_baud  <= '0;
            r_bit   <= 4'd0;
            r_shift <= '1;
        end else if (load && idle) begin
            r_busy  <= 1'b1;
            r_baud  <= '0;
            r_bit   <= 4'd0;
            r_shift <= {1'b1, data, 1'b0};
        end else if (r_busy) begin
            if (w_bit_end) begin
                r_baud  <= '0;
                r_bit   <= r_bit + 4'd1;
                r_shift <= {1'b1, r_shift[9:1]};
                if (r_bit == 4'd9) begin
                    r_busy <= 1'b0;
                end
            end else begin
                r_baud <= r_baud + BAUD_W'(1);
            end
        end
    end

endmodule

// File: rtl/nmea_sentence_tx.sv
// Frames a caller-supplied body as "$body*hh\r\n" and sends it UART 8N1 on tx.
// Define NMEA_TX_CKSUM_EN to include the "*hh" checksum; otherwise "$body\r\n" is sent.
module nmea_sentence_tx
    import nmea_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD_RATE   = 9600,
    parameter int MAX_BODY    = 76
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] body_data,
    input  logic       body_valid,
    input  logic       body_last,
    output logic       body_ready,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W        = $clog2(MAX_BODY + 1);
`ifdef NMEA_TX_CKSUM_EN
    localparam nmea_state_e ST_AFTER_BODY = ST_STAR;
`else
    localparam nmea_state_e ST_AFTER_BODY = ST_CR;
`endif

    nmea_state_e      r_state;
    nmea_state_e      w_next;
    logic [CNT_W-1:0] r_count;
    logic             r_err;
    logic             r_done;
    logic             w_load;
    logic [7:0]       w_data;
    logic             w_ser_rdy;
    logic             w_bit_done;
    logic             w_xfer;
    logic             w_body_end;
    logic             w_at_max;
`ifdef NMEA_TX_CKSUM_EN
    logic [7:0]       r_cks;
`endif

    nmea_uart_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .data    (w_data),
        .tx      (tx),
        .idle    (w_ser_rdy),
        .bit_done(w_bit_done)
    );

    assign w_xfer     = (r_state == ST_BODY) && w_ser_rdy && body_valid;
    assign w_at_max   = (r_count == CNT_W'(MAX_BODY - 1));
    assign w_body_end = body_last || w_at_max;

    assign body_ready = (r_state == ST_BODY) && w_ser_rdy;
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign err        = r_err;

    // State names the next character to hand the serializer; SOF covers the cycle '$' is launched.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_data = 8'hFF;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_data = ASCII_DOLLAR;
                    w_next = ST_SOF;
                end
            end
            ST_SOF: w_next = ST_BODY;
            ST_BODY: begin
                if (w_xfer) begin
                    w_load = 1'b1;
                    w_data = body_data;
                    if (w_body_end) begin
                        w_next = ST_AFTER_BODY;
                    end
                end
            end
`ifdef NMEA_TX_CKSUM_EN
            ST_STAR: begin
                if (w_ser_rdy) begin
                    w_load = 1'b1;
                    w_data = ASCII_STAR;
                    w_next = ST_HI;
                end
            end
            ST_HI: begin
                if (w_ser_rdy) begin
                    w_load = 1'b1;
                    w_data = nib2hex(r_cks[7:4]);
                    w_next = ST_LO;
                end
            end
            ST_LO: begin
                if (w_ser_rdy) begin
                    w_load = 1'b1;
                    w_data = nib2hex(r_cks[3:0]);
                    w_next = ST_CR;
                end
            end
`endif
            ST_CR: begin
                if (w_ser_rdy) begin
                    w_load = 1'b1;
                    w_data = ASCII_CR;
                    w_next = ST_LF;
                end
            end
            ST_LF: begin
                if (w_ser_rdy) begin
                    w_load = 1'b1;
                    w_data = ASCII_LF;
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_ser_rdy && w_bit_done) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
`ifdef NMEA_TX_CKSUM_EN
            r_cks   <= 8'h00;
`endif
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == ST_DONE) && w_ser_rdy && w_bit_done;
            if ((r_state == ST_IDLE) && start) begin
                r_count <= '0;
                r_err   <= 1'b0;
`ifdef NMEA_TX_CKSUM_EN
                r_cks   <= 8'h00;
`endif
            end else if (w_xfer) begin
                r_count <= r_count + CNT_W'(1);
`ifdef NMEA_TX_CKSUM_EN
                r_cks   <= r_cks ^ body_data;
`endif
                if (!body_last && w_at_max) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/nmea_sentence_tx.md
Name: nmea_sentence_tx

Overview:
- Builds complete NMEA/PMTK sentences from a caller-supplied body byte stream and serializes them UART 8N1 on one pin toward the GPS module.
- Used to send configuration commands, e.g. "$PMTK220,1000*1F" + CR LF. This is the write direction of the receive, filter and parse chain.
- Adds the leading '$', the XOR checksum '*hh' and the trailing CR LF itself; the caller supplies only the body between '$' and '*'.

Parameters:
- CLK_FREQ_HZ, 100000000, system clock frequency.
- BAUD_RATE, 9600, line rate. CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE (integer divide; 10416 at defaults).
- MAX_BODY, 76, maximum body bytes accepted (keeps the sentence within the 82-char NMEA limit).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a sentence; sampled only while busy=0
- body_data  in  8  body byte (ASCII)
- body_valid  in  1  body_data valid
- body_last  in  1  qualifies the final body byte
- body_ready  out  1  block accepts body_data this cycle (transfer = body_valid & body_ready)
- tx  out  1  serial line to the GPS module, idle high
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at sentence end
- err  out  1  sticky: body truncated at MAX_BODY; cleared by next accepted start

Behaviour:
- Reset values: tx=1, busy=0, done=0, body_ready=0, err=0, FSM=IDLE, checksum=0, body count=0. A reset mid-sentence aborts at once; tx returns high the next cycle.
- Frame timing:
  - Each character is one start bit (0), 8 data bits LSB first, one stop bit (1), each held exactly CLKS_PER_BIT cycles.
  - Characters are back-to-back: the next start bit begins the cycle after the previous stop bit ends.
- Start latency: start=1 in IDLE at cycle N gives busy=1 and tx=0 (start bit of '$') at cycle N+1. start while busy=1 is ignored.
- FSM states: IDLE -> SOF('$') -> BODY -> STAR('*') -> HI -> LO -> CR(0x0D) -> LF(0x0A) -> DONE -> IDLE.
- BODY state:
  - body_ready=1 only while in BODY and the serializer can load a new character: the cycle after the previous stop bit ends, or the first BODY cycle after '$' completes.
  - body_ready stays high until a transfer occurs. The serializer does not start while body_valid=0 (tx holds 1).
  - On transfer: the byte is transmitted, checksum ^= byte, count++.
  - body_last on the transferred byte moves the FSM to STAR after that byte's stop bit.
- Overflow: if count reaches MAX_BODY with no body_last, set err=1, drop body_ready and proceed to STAR. Further body bytes are not consumed.
- Checksum:
  - 8-bit XOR of body bytes only; '$' and '*' are excluded.
  - HI sends the upper nibble and LO the lower nibble, uppercase hex: n<10 -> 0x30+n, else 0x41+n-10.
- done=1 for exactly one cycle, in the cycle after the LF stop bit ends; busy=0 in that same cycle. A start in the done cycle is accepted.
- Empty body (body_last never seen, body_valid=0) stalls in BODY indefinitely with tx=1. Only reset recovers.

Optional Feature:
- NMEA_TX_CKSUM_EN defined: sentence carries "*hh" as above.
- NMEA_TX_CKSUM_EN undefined: STAR/HI/LO states and the checksum register are omitted. BODY goes directly to CR after the last body byte; sentence is "$body\r\n".

Decomposition:
- Shared package nmea_pkg:
  - ASCII constants: '$'=0x24, '*'=0x2A, ','=0x2C, CR=0x0D, LF=0x0A.
  - FSM state encoding.
  - nibble-to-hex function.
- One sub-module, nmea_uart_serializer:
  - Ports: clk, rst, load, data[7:0], tx, idle, bit_done.
  - Contains the baud counter and shift register. The parent FSM sequences characters into it.

Test Plan (sim with CLK_FREQ_HZ=1000, BAUD_RATE=100 -> 10 clks/bit):
- Basic sentence: start, body "PMTK220,1000" with last on '0'.
  - tx decodes to "$PMTK220,1000*1F\r\n" (18 chars).
  - done pulses exactly 18*10*10=1800 cycles after the start bit of '$'; err=0.
- RMC-only command: body "PMTK314,0,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0" -> checksum chars "29"; lowercase never emitted.
- Backpressure and ignored start:
  - Drop body_valid for 37 cycles mid-body -> tx stays 1 for the gap, byte order intact, checksum unchanged.
  - start pulsed while busy -> ignored.
- Overflow: MAX_BODY=4, body "ABCDEF" without last -> only "ABCD" sent, then "*04\r\n"; err=1 until the next start.
- Reset mid-sentence: assert rst during the data bits of 'K' -> next cycle tx=1, busy=0, done=0. A new start then produces a clean sentence.
- Macro off: without NMEA_TX_CKSUM_EN, body "PMTK000" -> "$PMTK000\r\n"; done after 10 chars.
